// File: rtl/apa102_frame_driver.sv
// APA102 multi-strand frame driver: per-LED pixel buffers shifted out in lock-step.
// Optional macro APA102_AUTO_REFRESH_EN adds a self-timed frame request.
module apa102_frame_driver #(
    parameter int NUM_CH    = 3,
    parameter int NUM_LEDS  = 12,
    parameter int CLK_DIV   = 64,
    parameter int END_WORDS = (NUM_LEDS + 63) / 64
`ifdef APA102_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 2**20
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] wr_addr,
    input  logic [28:0] wr_data,
    output logic wr_err,
    input  logic start,
    output logic busy,
    output logic done,
    output logic sck,
    output logic [NUM_CH-1:0] mosi
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int A_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WMAX  = (NUM_LEDS > END_WORDS) ? NUM_LEDS : END_WORDS;
    localparam int WC_W  = $clog2(WMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LEDS,
        S_END,
        S_FINISH
    } state_t;

    state_t state;

    logic [28:0] pix [NUM_CH][NUM_LEDS];
    logic [30:0] sr [NUM_CH];
    logic [31:0] led_word [NUM_CH];
    logic [31:0] nxt [NUM_CH];

    logic [DIV_W-1:0] div_cnt;
    logic phase;
    logic [4:0] bit_idx;
    logic [WC_W-1:0] wcnt;
    logic [A_W-1:0] rd_addr;

    logic wr_bad;
    logic wr_ok;
    logic rd_ok;
    logic div_last;
    logic led_last;
    logic end_last;
    logic go;

    assign wr_bad = (32'(wr_ch) >= NUM_CH) ||
                    (32'(wr_addr) >= NUM_LEDS);
    assign wr_ok  = wr_en && !busy && !wr_bad;
    assign rd_ok  = 32'(rd_addr) < NUM_LEDS;

    assign div_last = div_cnt == DIV_W'(CLK_DIV - 1);
    assign led_last = wcnt == WC_W'(NUM_LEDS - 1);
    assign end_last = wcnt == WC_W'(END_WORDS - 1);

`ifdef APA102_AUTO_REFRESH_EN
    localparam int RC_W = (REFRESH_CYCLES > 1) ?
                          $clog2(REFRESH_CYCLES) : 1;

    logic [RC_W-1:0] ref_cnt;
    logic ref_hit;

    assign ref_hit = ref_cnt == RC_W'(REFRESH_CYCLES - 1);
    assign go = start || (state == S_IDLE && ref_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt <= '0;
        end else if (state == S_FINISH) begin
            ref_cnt <= '0;
        end else if (state == S_IDLE && !ref_hit) begin
            ref_cnt <= ref_cnt + RC_W'(1);
        end
    end
`else
    assign go = start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int l = 0; l < NUM_LEDS; l++) begin
                    pix[c][l] <= '0;
                end
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (busy || wr_bad);
            if (wr_ok) begin
                pix[wr_ch][wr_addr] <= wr_data;
            end
        end
    end

    // rd_addr is advanced one word ahead, so the fetch is a plain mux
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            led_word[k] = 32'hE000_0000;
            if (rd_ok) begin
                led_word[k] = {3'b111, pix[k][rd_addr]};
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            nxt[k] = 32'hFFFF_FFFF;
            if (state == S_START ||
                (state == S_LEDS && !led_last)) begin
                nxt[k] = led_word[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_idx <= '0;
            wcnt    <= '0;
            rd_addr <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                sr[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                // FINISH also accepts start so held start leaves one idle cycle
                S_IDLE, S_FINISH: begin
                    sck   <= 1'b0;
                    mosi  <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (go) begin
                        state   <= S_START;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        phase   <= 1'b0;
                        bit_idx <= 5'd31;
                        wcnt    <= '0;
                        rd_addr <= '0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            sr[k] <= '0;
                        end
                    end
                end
                default: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (!phase) begin
                            sck <= 1'b1;
                        end else begin
                            sck <= 1'b0;
                            if (bit_idx != 5'd0) begin
                                bit_idx <= bit_idx - 5'd1;
                                for (int k = 0; k < NUM_CH; k++) begin
                                    mosi[k] <= sr[k][30];
                                    sr[k]   <= {sr[k][29:0], 1'b0};
                                end
                            end else begin
                                bit_idx <= 5'd31;
                                for (int k = 0; k < NUM_CH; k++) begin
                                    mosi[k] <= nxt[k][31];
                                    sr[k]   <= nxt[k][30:0];
                                end
                                unique case (state)
                                    S_START: begin
                                        state   <= S_LEDS;
                                        wcnt    <= '0;
                                        rd_addr <= rd_addr + A_W'(1);
                                    end
                                    S_LEDS: begin
                                        if (led_last) begin
                                            state <= S_END;
                                            wcnt  <= '0;
                                        end else begin
                                            wcnt    <= wcnt + WC_W'(1);
                                            rd_addr <= rd_addr + A_W'(1);
                                        end
                                    end
                                    default: begin
                                        if (end_last) begin
                                            state <= S_FINISH;
                                            busy  <= 1'b0;
                                            done  <= 1'b1;
                                            mosi  <= '0;
                                        end else begin
                                            wcnt <= wcnt + WC_W'(1);
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
